// File: rtl/acc_seq_pkg.sv
// Shared definitions for the accumulator program sequencer: instruction field layout,
// sequencer opcodes, ALU opcodes, FSM encoding and the decoded-control record.
package acc_seq_pkg;

  localparam int unsigned OpLsb      = 8;
  localparam int unsigned OpWidth    = 4;
  localparam int unsigned AluOpWidth = 3;

  typedef enum logic [OpWidth-1:0] {
    OpNop  = 4'h0, OpLd   = 4'h1, OpAdd  = 4'h2, OpSub  = 4'h3,
    OpAnd  = 4'h4, OpOr   = 4'h5, OpXor  = 4'h6, OpNot  = 4'h7,
    OpSt   = 4'h8, OpJmp  = 4'h9, OpJc   = 4'hA, OpJz   = 4'hB,
    OpIllC = 4'hC, OpIllD = 4'hD, OpIllE = 4'hE, OpHlt  = 4'hF
  } instr_op_e;

  typedef enum logic [AluOpWidth-1:0] {
    AluHold = 3'd0, AluLd  = 3'd1, AluAdd = 3'd2, AluSub = 3'd3,
    AluAnd  = 3'd4, AluOr  = 3'd5, AluXor = 3'd6, AluNot = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExecute = 3'd3,
    StHalt    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CondAlways = 2'd0,
    CondCarry  = 2'd1,
    CondZero   = 2'd2
  } jump_cond_e;

  typedef struct packed {
    alu_op_e    alu_opcode;
    logic       alu_ce;
    logic       cy_ce;
    logic       reg_we;
    logic       is_jump;
    jump_cond_e jump_cond;
    logic       is_halt;
    logic       is_illegal;
  } dec_t;

  // All-zero record: hold code, no strobes.
  localparam dec_t DecIdle = '0;

endpackage

// File: rtl/acc_seq_decode.sv
// Combinational instruction decoder: maps the opcode field of an instruction word to
// the control record consumed by the sequencer during EXECUTE.
module acc_seq_decode
  import acc_seq_pkg::*;
(
  input  logic [OpWidth-1:0] opcode,
  output dec_t               dec
);

  always_comb begin
    dec = DecIdle;
    case (instr_op_e'(opcode))
      OpLd:  begin dec.alu_opcode = AluLd;  dec.alu_ce = 1'b1; end
      OpAdd: begin dec.alu_opcode = AluAdd; dec.alu_ce = 1'b1; dec.cy_ce = 1'b1; end
      OpSub: begin dec.alu_opcode = AluSub; dec.alu_ce = 1'b1; dec.cy_ce = 1'b1; end
      OpAnd: begin dec.alu_opcode = AluAnd; dec.alu_ce = 1'b1; end
      OpOr:  begin dec.alu_opcode = AluOr;  dec.alu_ce = 1'b1; end
      OpXor: begin dec.alu_opcode = AluXor; dec.alu_ce = 1'b1; end
      OpNot: begin dec.alu_opcode = AluNot; dec.alu_ce = 1'b1; end
      OpSt:  dec.reg_we = 1'b1;
      OpJmp: begin dec.is_jump = 1'b1; dec.jump_cond = CondAlways; end
      OpJc:  begin dec.is_jump = 1'b1; dec.jump_cond = CondCarry;  end
      OpJz:  begin dec.is_jump = 1'b1; dec.jump_cond = CondZero;   end
      OpHlt: dec.is_halt = 1'b1;
      OpIllC, OpIllD, OpIllE: dec.is_illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_sequencer.sv
// Program sequencer for the 8-bit accumulator ALU: fixed FETCH/DECODE/EXECUTE cadence,
// registered ALU/register-file controls, jumps, halt and sticky illegal-opcode flag.
module acc_sequencer
  import acc_seq_pkg::*;
#(
  parameter int unsigned PC_WIDTH      = 8,
  parameter int unsigned REG_SEL_WIDTH = 4,
  parameter int unsigned INSTR_WIDTH   = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [PC_WIDTH-1:0]      rom_addr,
  input  logic [INSTR_WIDTH-1:0]   rom_data,
  output logic [AluOpWidth-1:0]    alu_opcode,
  output logic                     alu_ce,
  output logic                     cy_ce,
  output logic [REG_SEL_WIDTH-1:0] reg_sel,
  output logic                     reg_we,
  output logic [7:0]               reg_wdata,
  input  logic [7:0]               acc,
  input  logic                     cy,
  output logic                     busy,
  output logic                     halted,
  output logic                     illegal
);

  localparam int unsigned OperandWidth = INSTR_WIDTH - OpWidth;

  state_e                  state_q;
  logic [PC_WIDTH-1:0]     pc_q;
  logic [OperandWidth-1:0] operand_q;
  logic                    illegal_q;
  dec_t                    dec;
  dec_t                    dec_q;
  logic                    jump_taken;

  // Decode the word as it is latched into the instruction register so that every
  // EXECUTE-cycle control comes straight from a flop.
  acc_seq_decode u_decode (
    .opcode (rom_data[OpLsb +: OpWidth]),
    .dec    (dec)
  );

  // Conditions sample acc/cy live, i.e. the result of the previous instruction.
  always_comb begin
    jump_taken = 1'b0;
    if (dec_q.is_jump) begin
      case (dec_q.jump_cond)
        CondAlways: jump_taken = 1'b1;
        CondCarry:  jump_taken = cy;
        CondZero:   jump_taken = (acc == 8'h00);
        default:    jump_taken = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      operand_q <= '0;
      illegal_q <= 1'b0;
      dec_q     <= DecIdle;
    end else begin
      case (state_q)
        StIdle, StHalt: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= StFetch;
          end
        end
        StFetch: state_q <= StDecode;
        StDecode: begin
          operand_q <= rom_data[OperandWidth-1:0];
          dec_q     <= dec;
          state_q   <= StExecute;
        end
        StExecute: begin
          dec_q     <= DecIdle;
          illegal_q <= illegal_q | dec_q.is_illegal;
          if (dec_q.is_halt) begin
            state_q <= StHalt;
          end else begin
            pc_q    <= jump_taken ? operand_q[PC_WIDTH-1:0] : pc_q + PC_WIDTH'(1);
            state_q <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rom_addr   = pc_q;
  assign alu_opcode = dec_q.alu_opcode;
  assign alu_ce     = dec_q.alu_ce;
  assign cy_ce      = dec_q.cy_ce;
  assign reg_sel    = operand_q[REG_SEL_WIDTH-1:0];
  // Masked by rst so a reset during EXECUTE of ST never reaches the register file.
  assign reg_we     = dec_q.reg_we & ~rst;
  assign reg_wdata  = acc;
  assign busy       = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExecute);
  assign halted     = (state_q == StHalt);
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: ROM/register-file/ALU environment, an
// instruction-level reference model compared every cycle, directed and random programs.
module tb_acc_sequencer;
  import acc_seq_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [7:0]            rom_addr;
  logic [11:0]           rom_data = 12'h000;
  logic [AluOpWidth-1:0] alu_opcode;
  logic                  alu_ce, cy_ce, reg_we, busy, halted, illegal;
  logic [3:0]            reg_sel;
  logic [7:0]            reg_wdata;
  logic [7:0]            acc = 8'h00;
  logic                  cy = 1'b0;

  always #5 clk = ~clk;

  acc_sequencer #(.PC_WIDTH(8), .REG_SEL_WIDTH(4), .INSTR_WIDTH(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .alu_opcode (alu_opcode),
    .alu_ce     (alu_ce),
    .cy_ce      (cy_ce),
    .reg_sel    (reg_sel),
    .reg_we     (reg_we),
    .reg_wdata  (reg_wdata),
    .acc        (acc),
    .cy         (cy),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal)
  );

  // Environment: synchronous ROM, register file, accumulator ALU.
  logic [11:0] rom  [256];
  logic [7:0]  regs [16];

  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(posedge clk) if (reg_we) regs[reg_sel] <= reg_wdata;

  always @(posedge clk) begin
    logic [8:0] r;
    r = {cy, acc};
    case (alu_opcode)
      AluLd:  r[7:0] = regs[reg_sel];
      AluAdd: r = {1'b0, acc} + {1'b0, regs[reg_sel]};
      AluSub: r = {1'b0, acc} - {1'b0, regs[reg_sel]};
      AluAnd: r[7:0] = acc & regs[reg_sel];
      AluOr:  r[7:0] = acc | regs[reg_sel];
      AluXor: r[7:0] = acc ^ regs[reg_sel];
      AluNot: r[7:0] = ~acc;
      default: ;
    endcase
    acc <= r[7:0];
    if (cy_ce) cy <= r[8];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 fetch, 2 decode, 3 execute, 4 halt.
  int         m_phase = 0;
  logic [7:0] m_pc = 8'h00;
  logic [11:0] m_ir = 12'h000;
  logic       m_ill = 1'b0;

  always @(posedge clk) begin
    logic [3:0] op;
    logic       taken;
    op = m_ir[11:8];
    if (rst) begin
      m_phase = 0; m_pc = 8'h00; m_ir = 12'h000; m_ill = 1'b0;
    end else begin
      case (m_phase)
        0, 4: if (start) begin m_pc = 8'h00; m_phase = 1; end
        1: m_phase = 2;
        2: begin m_ir = rom_data; m_phase = 3; end
        3: begin
          if (op >= 4'hC && op <= 4'hE) m_ill = 1'b1;
          taken = (op == 4'h9) || (op == 4'hA && cy) || (op == 4'hB && acc == 8'h00);
          if (op == 4'hF) m_phase = 4;
          else begin
            m_pc = taken ? m_ir[7:0] : m_pc + 8'd1;
            m_phase = 1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  logic cmp_en = 1'b0;
  int   alu_ce_cnt = 0;
  int   cy_ce_cnt = 0;

  always @(negedge clk) begin
    logic [3:0] op;
    logic       exec, is_alu;
    if (cmp_en) begin
      op     = m_ir[11:8];
      exec   = (m_phase == 3);
      is_alu = exec && op >= 4'h1 && op <= 4'h7;
      chk("rom_addr", rom_addr, m_pc);
      chk("alu_opcode", alu_opcode, is_alu ? {29'd0, op[2:0]} : 32'd0);
      chk("alu_ce", alu_ce, is_alu);
      chk("cy_ce", cy_ce, exec && (op == 4'h2 || op == 4'h3));
      chk("reg_we", reg_we, exec && op == 4'h8 && !rst);
      chk("reg_sel", reg_sel, m_ir[3:0]);
      chk("reg_wdata", reg_wdata, acc);
      chk("busy", busy, m_phase >= 1 && m_phase <= 3);
      chk("halted", halted, m_phase == 4);
      chk("illegal", illegal, m_ill);
      if (!exec) chk("alu_hold", alu_opcode, AluHold);
      if (alu_ce) alu_ce_cnt++;
      if (cy_ce) cy_ce_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic run_to_halt(input int max, output int cycles);
    cycles = 0;
    while (!halted && cycles < max) begin
      tick(1);
      cycles++;
    end
    if (!halted) chk("halt_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_env();
    for (int i = 0; i < 256; i++) rom[i] = 12'hF00;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
  endtask

  int cyc;

  initial begin
    clear_env();
    do_reset();
    cmp_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_alu_opcode", alu_opcode, AluHold);

    // LD r1, ADD r2, ST r3, HLT
    regs[1] = 8'h05; regs[2] = 8'h03;
    rom[0] = 12'h101; rom[1] = 12'h202; rom[2] = 12'h803; rom[3] = 12'hF00;
    alu_ce_cnt = 0; cy_ce_cnt = 0;
    pulse_start();
    run_to_halt(100, cyc);
    chk("t1_cycles", cyc, 12);
    chk("t1_r3", regs[3], 8'h08);
    chk("t1_pc", rom_addr, 8'h03);
    chk("t1_alu_ce_cnt", alu_ce_cnt, 2);
    chk("t1_cy_ce_cnt", cy_ce_cnt, 1);

    // ADD with carry then JC 0x10, taken and not taken
    for (int k = 0; k < 2; k++) begin
      clear_env();
      do_reset();
      regs[1] = (k == 0) ? 8'hF0 : 8'h01; regs[2] = 8'h20;
      rom[0] = 12'h101; rom[1] = 12'h202; rom[2] = 12'hA10;
      pulse_start();
      run_to_halt(100, cyc);
      chk("t2_acc", acc, (k == 0) ? 8'h10 : 8'h21);
      chk("t2_cy", cy, (k == 0) ? 1 : 0);
      chk("t2_pc", rom_addr, (k == 0) ? 8'h10 : 8'h03);
    end

    // JZ with acc 0 jumps, acc 1 falls through
    for (int k = 0; k < 2; k++) begin
      clear_env();
      do_reset();
      regs[1] = k[7:0];
      rom[0] = 12'h101; rom[1] = 12'hB20;
      pulse_start();
      run_to_halt(100, cyc);
      chk("t3_jz_pc", rom_addr, (k == 0) ? 8'h20 : 8'h02);
    end

    // JMP 0xFF then NOP at 0xFF wraps to 0
    clear_env();
    do_reset();
    rom[0] = 12'h9FF; rom[255] = 12'h000;
    pulse_start();
    tick(3);
    chk("wrap_jmp", rom_addr, 8'hFF);
    tick(3);
    chk("wrap_pc", rom_addr, 8'h00);
    chk("wrap_busy", busy, 1);

    // Illegal opcode at addr 2; execution continues, acc untouched, flag sticky
    clear_env();
    do_reset();
    regs[1] = 8'h42;
    rom[0] = 12'h101; rom[1] = 12'h000; rom[2] = 12'hC00; rom[3] = 12'hF00;
    pulse_start();
    run_to_halt(100, cyc);
    chk("ill_flag", illegal, 1);
    chk("ill_pc", rom_addr, 8'h03);
    chk("ill_acc", acc, 8'h42);
    pulse_start();
    chk("halt_restart_pc", rom_addr, 8'h00);
    chk("halt_restart_busy", busy, 1);
    chk("ill_sticky", illegal, 1);

    // start mid-run ignored; rst during EXECUTE of ST suppresses the write
    clear_env();
    do_reset();
    regs[1] = 8'h77;
    rom[0] = 12'h101; rom[1] = 12'h803;
    pulse_start();
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("start_ignored_pc", rom_addr, 8'h01);
    tick(2);
    rst = 1'b1;
    #1;
    chk("st_rst_we", reg_we, 0);
    tick(1);
    rst = 1'b0;
    chk("st_rst_r3", regs[3], 8'h00);
    chk("st_rst_busy", busy, 0);
    chk("st_rst_halted", halted, 0);
    chk("st_rst_sel", reg_sel, 0);
    chk("st_rst_alu_ce", alu_ce, 0);
    tick(2);
    chk("idle_stays", busy, 0);

    // Random programs with random start/rst pulses
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 256; i++) begin
        logic [3:0] op;
        op = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        rom[i] = {op, 8'($urandom)};
      end
      for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
      do_reset();
      pulse_start();
      for (int c = 0; c < 600; c++) begin
        start = ($urandom_range(0, 39) == 0);
        rst = ($urandom_range(0, 299) == 0);
        tick(1);
      end
      start = 1'b0;
      rst = 1'b0;
    end

    tick(1);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
